// File: rtl/mem_ctl_mem_responder.sv
// Memory-side responder for the mem_write/mem_read/mem_done handshake.
// Optional MEM_CTL_RESP_STATS_EN adds saturating wr_count/rd_count outputs.
module mem_ctl_mem_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] rdata,
  output logic              proto_err
`ifdef MEM_CTL_RESP_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] ram [DEPTH];

  logic req_one;
  logic req_both;
  logic op_req;
  logic commit;

  assign req_one  = mem_write ^ mem_read;
  assign req_both = mem_write & mem_read;
  assign op_req   = op_wr ? mem_write : mem_read;
  assign commit   = (state == BUSY) && op_req && (cnt == 4'd0);

  // Storage is never reset; state is, so commit is low during reset.
  always_ff @(posedge clk) begin
    if (commit && op_wr) ram[addr_l] <= wdata_l;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      mem_done  <= 1'b0;
      rdata     <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          unique case (1'b1)
            req_both: proto_err <= 1'b1;
            req_one: begin
              op_wr   <= mem_write;
              addr_l  <= addr;
              wdata_l <= wdata;
              cnt     <= CNT_INIT;
              state   <= BUSY;
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (!op_req) begin
            state     <= IDLE;
            proto_err <= 1'b1;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_wr) rdata <= ram[addr_l];
            mem_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!mem_write && !mem_read) begin
            mem_done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_CTL_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 16'd0;
      rd_count <= 16'd0;
    end else if (commit) begin
      if (op_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (!op_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctl_mem_responder.sv
// Scoreboard bench for mem_ctl_mem_responder: random and directed
// accesses checked against a word-array reference model.
module tb_mem_ctl_mem_responder;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_write = 1'b0;
  logic       mem_read = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       mem_done;
  logic [7:0] rdata;
  logic       proto_err;
`ifdef MEM_CTL_RESP_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  mem_ctl_mem_responder #(
    .ADDR_W(4),
    .DATA_W(8),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .addr(addr),
    .wdata(wdata),
    .mem_done(mem_done),
    .rdata(rdata),
    .proto_err(proto_err)
`ifdef MEM_CTL_RESP_STATS_EN
    ,
    .wr_count(wr_count),
    .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [16];
  int         checks = 0;
  int         errors = 0;
  int         perr_exp = 0;
  int         perr_seen = 0;
  int         wr_n = 0;
  int         rd_n = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic       done_q = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every mem_done rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q    = 1'b0;
      exp_rdata = 8'h00;
    end else begin
      if (proto_err) perr_seen++;
      if (mem_done && !done_q) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.rd) begin
            exp_rdata = e.d;
            chk("read_data", {24'd0, rdata}, {24'd0, e.d});
          end
        end
      end
      chk("rdata_hold", {24'd0, rdata}, {24'd0, exp_rdata});
      done_q = mem_done;
    end
  end

  task automatic access(bit is_wr, logic [3:0] a, logic [7:0] d);
    exp_t e;
    int   cyc;
    @(negedge clk);
    mem_write = is_wr;
    mem_read  = !is_wr;
    addr      = a;
    wdata     = d;
    e.rd = !is_wr;
    e.d  = model[a];
    if (is_wr) begin
      model[a] = d;
      wr_n++;
    end else begin
      rd_n++;
    end
    q.push_back(e);
    @(negedge clk);
    cyc = 0;
    while (!mem_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, LAT);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    @(negedge clk);
    chk("done_fall", {31'd0, mem_done}, 32'd0);
  endtask

  task automatic abort_wr(logic [3:0] a, logic [7:0] d);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    perr_exp++;
    chk("abort_perr", {31'd0, proto_err}, 32'd1);
    chk("abort_done", {31'd0, mem_done}, 32'd0);
  endtask

  task automatic both_req(int n);
    @(negedge clk);
    mem_write = 1'b1;
    mem_read  = 1'b1;
    addr      = 4'($urandom);
    wdata     = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("both_done", {31'd0, mem_done}, 32'd0);
      chk("both_perr", {31'd0, proto_err}, 32'd1);
    end
    perr_exp += n;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic reset_mid(logic [3:0] a, logic [7:0] d);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    wr_n = 0;
    rd_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_done", {31'd0, mem_done}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    chk("reset_perr", {31'd0, proto_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) access(1'b1, 4'(i), 8'($urandom));

    access(1'b1, 4'h3, 8'hA5);
    access(1'b0, 4'h3, 8'h00);

    access(1'b1, 4'h7, 8'h00);
    abort_wr(4'h7, 8'h3C);
    access(1'b0, 4'h7, 8'h00);

    both_req(3);

    access(1'b1, 4'h1, 8'h11);
    access(1'b1, 4'h2, 8'h22);
    access(1'b0, 4'h1, 8'h00);
    access(1'b0, 4'h2, 8'h00);

    reset_mid(4'h5, 8'hFF);
    access(1'b0, 4'h5, 8'h00);

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4) access(1'b1, 4'($urandom), 8'($urandom));
      else if (k < 8) access(1'b0, 4'($urandom), 8'h00);
      else if (k == 8) abort_wr(4'($urandom), 8'($urandom));
      else both_req($urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    chk("perr_count", perr_seen, perr_exp);
    chk("queue_empty", q.size(), 0);
`ifdef MEM_CTL_RESP_STATS_EN
    chk("wr_count", {16'd0, wr_count}, wr_n);
    chk("rd_count", {16'd0, rd_count}, rd_n);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
